pwm_capture: RTL and testbench

- Receive-side counterpart of the pwm generator: measures an incoming PWM waveform and recovers its duty code and period.
- Sits at the feedback/monitor input of the amplifier path. Lets the PWM chain be looped back and checked, and lets an external PWM source be decoded.
- Counts in units of the same step strobe the generator uses, so a generator with duty width N gives back its exact duty code.

---
 rtl/pwm_capture.sv | 183 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform and recovers its duty code and period.
// Optional glitch filter after the synchronizer is enabled with `define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int N       = 4,
  parameter int CW      = N + 2,
  parameter int TIMEOUT = 2 ** (N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          step,
  input  logic          pwm_in,
  output logic [N-1:0]  duty,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          stuck
);

  localparam logic [1:0] WAIT_RISE = 2'd0;
  localparam logic [1:0] MEAS_HIGH = 2'd1;
  localparam logic [1:0] MEAS_LOW  = 2'd2;

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] DUTY_MAX  = CW'((2 ** N) - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          prev;
  logic          rise;
  logic          fall;
  logic          any_edge;
  logic          timeout;
  logic          armed;
  logic [1:0]    state;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] pcnt;
  logic [CW-1:0] first_cnt;
  logic [IW-1:0] idle;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  // Level only moves once three consecutive synchronized samples agree.
  logic hist1;
  logic hist2;
  logic filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist1  <= 1'b0;
      hist2  <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      hist1  <= sync2;
      hist2  <= hist1;
      filt_q <= level;
    end
  end

  always_comb begin
    level = filt_q;
    if (sync2 && hist1 && hist2) begin
      level = 1'b1;
    end else if (!sync2 && !hist1 && !hist2) begin
      level = 1'b0;
    end
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise     = level & ~prev;
  assign fall     = ~level & prev;
  assign any_edge = rise | fall;

  // The step coinciding with an edge is the first step of the new phase.
  assign first_cnt = CW'(step);

  // Timeout reports once, then stays quiet until a full period re-arms it.
  assign timeout = step & ~any_edge & armed & (idle == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= WAIT_RISE;
      hcnt   <= '0;
      pcnt   <= '0;
      idle   <= '0;
      armed  <= 1'b1;
      duty   <= '0;
      period <= '0;
      valid  <= 1'b0;
      stuck  <= 1'b0;
    end else if (!ena) begin
      state <= WAIT_RISE;
      hcnt  <= '0;
      pcnt  <= '0;
      idle  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;

      if (any_edge) begin
        idle <= '0;
      end else if (step && (idle != IDLE_MAX)) begin
        idle <= idle + IW'(1);
      end

      if (timeout) begin
        state  <= WAIT_RISE;
        hcnt   <= '0;
        pcnt   <= '0;
        duty   <= {N{level}};
        period <= '0;
        stuck  <= 1'b1;
        valid  <= 1'b1;
        armed  <= 1'b0;
      end else begin
        case (state)
          WAIT_RISE: begin
            if (rise) begin
              state <= MEAS_HIGH;
              hcnt  <= first_cnt;
              pcnt  <= first_cnt;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              state <= MEAS_LOW;
              if (step) begin
                pcnt <= sat_inc(pcnt);
              end
            end else if (step) begin
              hcnt <= sat_inc(hcnt);
              pcnt <= sat_inc(pcnt);
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              duty   <= (hcnt > DUTY_MAX) ? {N{1'b1}} : hcnt[N-1:0];
              period <= pcnt;
              stuck  <= 1'b0;
              valid  <= 1'b1;
              armed  <= 1'b1;
              state  <= MEAS_HIGH;
              hcnt   <= first_cnt;
              pcnt   <= first_cnt;
            end else if (step) begin
              pcnt <= sat_inc(pcnt);
            end
          end
          default: begin
            state <= WAIT_RISE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (N=4, step tied high).
module tb_pwm_capture;

  localparam int N       = 4;
  localparam int CW      = N + 2;
  localparam int TIMEOUT = 32;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT      = 5;
  localparam int SWEEP_LO = 3;
  localparam int SWEEP_HI = 13;
  localparam int GL_DUTY  = 8;
  localparam int GL_PER   = 16;
`else
  localparam int LAT      = 3;
  localparam int SWEEP_LO = 1;
  localparam int SWEEP_HI = 15;
  localparam int GL_DUTY  = 3;
  localparam int GL_PER   = 5;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic          step = 1'b1;
  logic          pwm_in = 1'b0;
  logic [N-1:0]  duty;
  logic [CW-1:0] period;
  logic          valid;
  logic          stuck;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcount = 0;
  int last_cyc = 0;
  int last_gap = 0;
  int fall_cyc = 0;
  int last_duty = 0;
  int last_period = 0;
  int last_stuck = 0;

  pwm_capture #(.N(N), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ena(ena), .step(step), .pwm_in(pwm_in),
    .duty(duty), .period(period), .valid(valid), .stuck(stuck)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      last_duty   = int'(duty);
      last_period = int'(period);
      last_stuck  = int'(stuck);
      last_gap    = cyc - last_cyc;
      last_cyc    = cyc;
    end
  end

  task automatic drive_period(input int d);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      pwm_in = (i < d) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pwm_in = lvl;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (duty !== 4'd0) begin failures++; $display("FAIL reset_duty: got %0d expected 0", duty); end
    checks++; if (period !== 6'd0) begin failures++; $display("FAIL reset_period: got %0d expected 0", period); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL reset_stuck: got %0b expected 0", stuck); end
    rst = 1'b0;
  endtask

  task automatic test_loopback();
    vcount = 0;
    for (int p = 0; p < 6; p++) drive_period(5);
    checks++; if (vcount !== 5) begin failures++; $display("FAIL loop_count: got %0d expected 5", vcount); end
    checks++; if (last_duty !== 5) begin failures++; $display("FAIL loop_duty: got %0d expected 5", last_duty); end
    checks++; if (last_period !== 16) begin failures++; $display("FAIL loop_period: got %0d expected 16", last_period); end
    checks++; if (last_stuck !== 0) begin failures++; $display("FAIL loop_stuck: got %0d expected 0", last_stuck); end
    checks++; if (last_gap !== 16) begin failures++; $display("FAIL loop_gap: got %0d expected 16", last_gap); end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i >= 1 && i <= LAT + 1) begin
        checks++;
        if (valid !== ((i == LAT) ? 1'b1 : 1'b0)) begin
          failures++; $display("FAIL latency_edge%0d: got %0b expected %0b", i, valid, (i == LAT));
        end
      end
      if (i == 5) fall_cyc = cyc;
      pwm_in = (i < 5) ? 1'b1 : 1'b0;
    end
    checks++; if (last_duty !== 5) begin failures++; $display("FAIL latency_duty: got %0d expected 5", last_duty); end
  endtask

  task automatic test_timeout_low();
    vcount = 0;
    hold(1'b0, 40);
    checks++; if (vcount !== 1) begin failures++; $display("FAIL tlow_count: got %0d expected 1", vcount); end
    checks++; if (last_duty !== 0) begin failures++; $display("FAIL tlow_duty: got %0d expected 0", last_duty); end
    checks++; if (last_period !== 0) begin failures++; $display("FAIL tlow_period: got %0d expected 0", last_period); end
    checks++; if (last_stuck !== 1) begin failures++; $display("FAIL tlow_stuck: got %0d expected 1", last_stuck); end
    checks++; if (last_cyc - fall_cyc !== LAT + TIMEOUT) begin
      failures++; $display("FAIL tlow_time: got %0d expected %0d", last_cyc - fall_cyc, LAT + TIMEOUT);
    end
    hold(1'b0, 40);
    checks++; if (vcount !== 1) begin failures++; $display("FAIL tlow_silent: got %0d expected 1", vcount); end
  endtask

  task automatic test_recovery();
    vcount = 0;
    drive_period(5);
    checks++; if (vcount !== 0) begin failures++; $display("FAIL recov_first: got %0d expected 0", vcount); end
    drive_period(5);
    checks++; if (vcount !== 1) begin failures++; $display("FAIL recov_count: got %0d expected 1", vcount); end
    checks++; if (last_stuck !== 0) begin failures++; $display("FAIL recov_stuck: got %0d expected 0", last_stuck); end
    checks++; if (last_duty !== 5) begin failures++; $display("FAIL recov_duty: got %0d expected 5", last_duty); end
    checks++; if (last_period !== 16) begin failures++; $display("FAIL recov_period: got %0d expected 16", last_period); end
  endtask

  task automatic test_timeout_high();
    vcount = 0;
    hold(1'b1, 50);
    checks++; if (vcount !== 2) begin failures++; $display("FAIL thigh_count: got %0d expected 2", vcount); end
    checks++; if (last_duty !== 15) begin failures++; $display("FAIL thigh_duty: got %0d expected 15", last_duty); end
    checks++; if (last_stuck !== 1) begin failures++; $display("FAIL thigh_stuck: got %0d expected 1", last_stuck); end
    checks++; if (last_period !== 0) begin failures++; $display("FAIL thigh_period: got %0d expected 0", last_period); end
    hold(1'b0, 40);
    checks++; if (vcount !== 2) begin failures++; $display("FAIL thigh_silent: got %0d expected 2", vcount); end
  endtask

  task automatic test_sweep();
    for (int d = SWEEP_LO; d <= SWEEP_HI; d++) begin
      for (int p = 0; p < 3; p++) drive_period(d);
      checks++; if (last_duty !== d) begin failures++; $display("FAIL sweep_duty%0d: got %0d expected %0d", d, last_duty, d); end
      checks++; if (last_period !== 16) begin failures++; $display("FAIL sweep_period%0d: got %0d expected 16", d, last_period); end
    end
  endtask

  task automatic test_disable();
    drive_period(5);
    drive_period(5);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 8) begin ena = 1'b0; vcount = 0; end
      pwm_in = (i < 5) ? 1'b1 : 1'b0;
    end
    drive_period(5);
    drive_period(5);
    checks++; if (vcount !== 0) begin failures++; $display("FAIL dis_count: got %0d expected 0", vcount); end
    checks++; if (duty !== 4'd5) begin failures++; $display("FAIL dis_duty: got %0d expected 5", duty); end
    checks++; if (period !== 6'd16) begin failures++; $display("FAIL dis_period: got %0d expected 16", period); end
    checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL dis_stuck: got %0b expected 0", stuck); end
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 8) ena = 1'b1;
      pwm_in = (i < 5) ? 1'b1 : 1'b0;
    end
    drive_period(9);
    checks++; if (vcount !== 0) begin failures++; $display("FAIL reen_first: got %0d expected 0", vcount); end
    drive_period(9);
    checks++; if (vcount !== 1) begin failures++; $display("FAIL reen_count: got %0d expected 1", vcount); end
    checks++; if (last_duty !== 9) begin failures++; $display("FAIL reen_duty: got %0d expected 9", last_duty); end
    checks++; if (last_period !== 16) begin failures++; $display("FAIL reen_period: got %0d expected 16", last_period); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 12) begin rst = 1'b1; vcount = 0; end
      if (i == 13) begin
        checks++; if (duty !== 4'd0) begin failures++; $display("FAIL rmid_duty: got %0d expected 0", duty); end
        checks++; if (period !== 6'd0) begin failures++; $display("FAIL rmid_period: got %0d expected 0", period); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %0b expected 0", valid); end
        checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL rmid_stuck: got %0b expected 0", stuck); end
        rst = 1'b0;
      end
      pwm_in = (i < 9) ? 1'b1 : 1'b0;
    end
    drive_period(9);
    checks++; if (vcount !== 0) begin failures++; $display("FAIL rmid_spurious: got %0d expected 0", vcount); end
  endtask

  task automatic test_glitch();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        pwm_in = (i < 8 && i != 3 && i != 4) ? 1'b1 : 1'b0;
      end
    end
    checks++; if (last_duty !== GL_DUTY) begin failures++; $display("FAIL glitch_duty: got %0d expected %0d", last_duty, GL_DUTY); end
    checks++; if (last_period !== GL_PER) begin failures++; $display("FAIL glitch_period: got %0d expected %0d", last_period, GL_PER); end
    checks++; if (last_stuck !== 0) begin failures++; $display("FAIL glitch_stuck: got %0d expected 0", last_stuck); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_latency();
    test_timeout_low();
    test_recovery();
    test_timeout_high();
    test_sweep();
    test_disable();
    test_reset_mid();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
